// File: rtl/pitch_frame_sequencer.sv
// pitch_frame_sequencer: circular-buffer framer that streams overlapping FRAME_LEN-sample
// windows to a pitch engine, advancing HOP new samples between frames.
module pitch_frame_sequencer #(
    parameter int DWIDTH    = 24,
    parameter int FRAME_LEN = 1024,
    parameter int HOP       = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DWIDTH-1:0] input_signal_data,
    input  logic              input_signal_valid,
    output logic              input_signal_ready,
    output logic [DWIDTH-1:0] frame_data,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic              frame_last,
    input  logic              engine_busy,
    output logic [15:0]       frame_count,
    output logic [1:0]        state_dbg
);
    localparam int AW = $clog2(FRAME_LEN);
    localparam logic [AW:0] L_LEN  = (AW+1)'(FRAME_LEN);
    localparam logic [AW:0] L_LAST = (AW+1)'(FRAME_LEN - 1);
    localparam logic [AW:0] L_HOP  = (AW+1)'(HOP);

    typedef enum logic [1:0] {FILL = 2'd0, WAIT_HOP = 2'd1, WAIT_ENGINE = 2'd2, STREAM = 2'd3} state_t;

    state_t            r_state;
    logic [DWIDTH-1:0] r_mem [FRAME_LEN];
    logic [AW-1:0]     r_wptr, r_rbase;
    logic [AW:0]       r_hop, r_issue, r_done;
    logic              r_armed, r_rd_valid, r_rd_last, r_out_valid, r_out_last;
    logic [DWIDTH-1:0] r_rd_data, r_out_data;
    logic [15:0]       r_frame_count;
    logic              w_accept, w_pop, w_s2_load, w_start, w_issue;
    logic [AW:0]       w_hop_next, w_idx;
    logic [AW-1:0]     w_raddr;

    // In STREAM a slot may be overwritten only once its beat has been consumed (r_hop < r_done).
    always_comb begin
        input_signal_ready = !reset && ((r_state == FILL && r_armed) || r_state == WAIT_HOP ||
                             (r_state == STREAM && r_hop < r_done && r_hop < L_HOP));
        w_accept   = input_signal_valid && input_signal_ready;
        w_hop_next = r_hop + (AW+1)'(w_accept);
        w_pop      = r_out_valid && frame_ready;
        w_s2_load  = r_rd_valid && (!r_out_valid || w_pop);
        w_start    = r_state == WAIT_ENGINE && !engine_busy;
        w_idx      = w_start ? '0 : r_issue;
        w_issue    = w_start || (r_state == STREAM && r_issue < L_LEN && (!r_rd_valid || w_s2_load));
        w_raddr    = (w_start ? r_wptr : r_rbase) + w_idx[AW-1:0];
    end

    assign frame_data  = r_out_data;
    assign frame_valid = r_out_valid && !reset;
    assign frame_last  = r_out_valid && r_out_last && !reset;
    assign frame_count = r_frame_count;
    assign state_dbg   = r_state;

    always_ff @(posedge clk) begin
        if (w_accept) r_mem[r_wptr] <= input_signal_data;
        if (w_issue) r_rd_data <= r_mem[w_raddr];
    end

    // Two-stage read pipeline (RAM register, output register) keeps full rate under backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= FILL;
            r_armed       <= 1'b0;
            r_wptr        <= '0;
            r_rbase       <= '0;
            r_hop         <= '0;
            r_issue       <= '0;
            r_done        <= '0;
            r_rd_valid    <= 1'b0;
            r_rd_last     <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_last    <= 1'b0;
            r_out_data    <= '0;
            r_frame_count <= '0;
        end else begin
            r_armed <= 1'b1;
            if (w_accept) begin
                r_wptr <= r_wptr + AW'(1);
                r_hop  <= w_hop_next;
            end
            if (w_issue) begin
                r_rd_valid <= 1'b1;
                r_rd_last  <= w_idx == L_LAST;
                r_issue    <= w_idx + (AW+1)'(1);
            end else if (w_s2_load) begin
                r_rd_valid <= 1'b0;
            end
            if (w_s2_load) begin
                r_out_valid <= 1'b1;
                r_out_last  <= r_rd_last;
                r_out_data  <= r_rd_data;
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
            if (w_pop) r_done <= r_done + (AW+1)'(1);
            if (r_state == FILL && w_accept && w_hop_next == L_LEN) r_state <= WAIT_ENGINE;
            if (r_state == WAIT_HOP && w_accept && w_hop_next == L_HOP) r_state <= WAIT_ENGINE;
            if (w_start) begin
                r_state <= STREAM;
                r_rbase <= r_wptr;
                r_hop   <= '0;
                r_done  <= '0;
            end
            if (r_state == STREAM && w_pop && r_out_last) begin
                r_frame_count <= r_frame_count + 16'd1;
                r_state       <= (w_hop_next == L_HOP) ? WAIT_ENGINE : WAIT_HOP;
            end
        end
    end
endmodule

// File: tb/tb_pitch_frame_sequencer.sv
// tb_pitch_frame_sequencer: directed scenarios for the framer with FRAME_LEN=8, HOP=4.
module tb_pitch_frame_sequencer;
    localparam int DW = 16, FL = 8, HP = 4;

    logic          clk = 1'b0, reset = 1'b1;
    logic [DW-1:0] input_signal_data = '0;
    logic          input_signal_valid = 1'b0, input_signal_ready;
    logic [DW-1:0] frame_data;
    logic          frame_valid, frame_ready = 1'b1, frame_last;
    logic          engine_busy = 1'b0;
    logic [15:0]   frame_count;
    logic [1:0]    state_dbg;

    pitch_frame_sequencer #(.DWIDTH(DW), .FRAME_LEN(FL), .HOP(HP)) dut (
        .clk(clk), .reset(reset),
        .input_signal_data(input_signal_data), .input_signal_valid(input_signal_valid),
        .input_signal_ready(input_signal_ready),
        .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
        .frame_last(frame_last), .engine_busy(engine_busy),
        .frame_count(frame_count), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0, cyc = 0, next_sample = 1, acc_cnt = 0, viol = 0;
    logic [DW-1:0] bq[$];
    logic          lq[$];
    int            cq[$];
    logic [15:0]   fq[$];
    logic          prev_stall = 1'b0, prev_last = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Beat monitor at negedge: records completed beats and protocol violations.
    always @(negedge clk) begin
        if (frame_last && !frame_valid) viol++;
        if (prev_stall && !reset && !(frame_valid && frame_data == prev_data && frame_last == prev_last)) viol++;
        prev_stall = frame_valid && !frame_ready;
        prev_data  = frame_data;
        prev_last  = frame_last;
        if (frame_valid && frame_ready) begin
            bq.push_back(frame_data);
            lq.push_back(frame_last);
            cq.push_back(cyc);
            fq.push_back(frame_count);
        end
    end

    // Sample source: a value advances only after it has been accepted.
    initial begin
        logic hs;
        forever begin
            @(negedge clk);
            hs = input_signal_valid && input_signal_ready;
            if (hs) acc_cnt++;
            @(posedge clk);
            #1;
            if (hs) begin
                next_sample++;
                input_signal_data = DW'(next_sample);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset(input int start);
        @(posedge clk); #1;
        reset = 1'b1;
        input_signal_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        next_sample = start;
        input_signal_data = DW'(start);
        bq.delete(); lq.delete(); cq.delete(); fq.delete();
        viol = 0;
    endtask

    task automatic wait_beats(input int n, input int budget, output logic ok);
        int k = 0;
        ok = 1'b0;
        while (k < budget && !ok) begin
            @(posedge clk); #1;
            ok = bq.size() >= n;
            k++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        input_signal_valid = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (state_dbg !== 2'd0) $display("FAIL reset_state: got %0d expected 0", state_dbg); else n_pass++;
        n_checks++; if (frame_count !== 16'd0) $display("FAIL reset_count: got %0d expected 0", frame_count); else n_pass++;
        n_checks++; if (frame_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", frame_valid); else n_pass++;
        n_checks++; if (frame_last !== 1'b0) $display("FAIL reset_last: got %0b expected 0", frame_last); else n_pass++;
        n_checks++; if (input_signal_ready !== 1'b0) $display("FAIL reset_ready_during: got %0b expected 0", input_signal_ready); else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (input_signal_ready !== 1'b0) $display("FAIL reset_ready_after: got %0b expected 0", input_signal_ready); else n_pass++;
        @(negedge clk);
        n_checks++; if (input_signal_ready !== 1'b1) $display("FAIL fill_ready: got %0b expected 1", input_signal_ready); else n_pass++;
    endtask

    task automatic test_stream;
        logic ok;
        engine_busy = 1'b0;
        frame_ready = 1'b1;
        do_reset(1);
        input_signal_valid = 1'b1;
        wait_beats(24, 300, ok);
        if (!ok) begin n_checks++; $display("FAIL stream_timeout: got %0d beats expected 24", bq.size()); end
        else begin
            n_checks++; if (frame_count !== 16'd3) $display("FAIL stream_count: got %0d expected 3", frame_count); else n_pass++;
            for (int i = 0; i < 24; i++) begin
                n_checks++; if (bq[i] !== DW'((i / 8) * 4 + (i % 8) + 1)) $display("FAIL stream_data[%0d]: got %0d expected %0d", i, bq[i], (i / 8) * 4 + (i % 8) + 1); else n_pass++;
                n_checks++; if (lq[i] !== (i % 8 == 7)) $display("FAIL stream_last[%0d]: got %0b expected %0b", i, lq[i], i % 8 == 7); else n_pass++;
            end
            n_checks++; if (fq[7] !== 16'd0 || fq[8] !== 16'd1 || fq[16] !== 16'd2) $display("FAIL stream_fc_progress: got %0d,%0d,%0d expected 0,1,2", fq[7], fq[8], fq[16]); else n_pass++;
            n_checks++; if (cq[7] - cq[0] !== 7) $display("FAIL back_to_back_f1: got span %0d expected 7", cq[7] - cq[0]); else n_pass++;
            n_checks++; if (cq[15] - cq[8] !== 7) $display("FAIL back_to_back_f2: got span %0d expected 7", cq[15] - cq[8]); else n_pass++;
        end
        n_checks++; if (viol !== 0) $display("FAIL stream_protocol: got %0d violations expected 0", viol); else n_pass++;
    endtask

    task automatic test_engine_busy;
        logic ok;
        int k = 0, bad = 0, t0;
        engine_busy = 1'b1;
        frame_ready = 1'b1;
        do_reset(1);
        input_signal_valid = 1'b1;
        while (k < 50 && state_dbg != 2'd2) begin @(posedge clk); #1; k++; end
        n_checks++; if (state_dbg !== 2'd2) $display("FAIL busy_fill_state: got %0d expected 2", state_dbg); else n_pass++;
        repeat (20) begin
            @(negedge clk);
            if (input_signal_ready || frame_valid) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL busy_hold: got %0d active cycles expected 0", bad); else n_pass++;
        n_checks++; if (bq.size() !== 0) $display("FAIL busy_beats: got %0d beats expected 0", bq.size()); else n_pass++;
        @(posedge clk); #1;
        engine_busy = 1'b0;
        t0 = cyc;
        wait_beats(8, 100, ok);
        if (!ok) begin n_checks++; $display("FAIL busy_timeout: got %0d beats expected 8", bq.size()); end
        else begin
            n_checks++; if (cq[0] - t0 > 2) $display("FAIL busy_latency: got %0d cycles expected <=2", cq[0] - t0); else n_pass++;
            for (int i = 0; i < 8; i++) begin
                n_checks++; if (bq[i] !== DW'(i + 1)) $display("FAIL busy_data[%0d]: got %0d expected %0d", i, bq[i], i + 1); else n_pass++;
            end
        end
    endtask

    task automatic test_ready_toggle;
        logic [31:0] pat = 32'hB2E5_9C6B;
        int k = 0;
        engine_busy = 1'b0;
        frame_ready = 1'b1;
        do_reset(1);
        input_signal_valid = 1'b1;
        while (k < 400 && bq.size() < 16) begin
            @(posedge clk); #1;
            frame_ready = pat[k % 32];
            k++;
        end
        frame_ready = 1'b1;
        if (bq.size() < 16) begin n_checks++; $display("FAIL toggle_timeout: got %0d beats expected 16", bq.size()); end
        else begin
            for (int i = 0; i < 16; i++) begin
                n_checks++; if (bq[i] !== DW'((i / 8) * 4 + (i % 8) + 1)) $display("FAIL toggle_data[%0d]: got %0d expected %0d", i, bq[i], (i / 8) * 4 + (i % 8) + 1); else n_pass++;
            end
            n_checks++; if (lq[7] !== 1'b1 || lq[15] !== 1'b1 || lq[6] !== 1'b0) $display("FAIL toggle_last: got %0b%0b%0b expected 110", lq[7], lq[15], lq[6]); else n_pass++;
        end
        n_checks++; if (viol !== 0) $display("FAIL toggle_stability: got %0d violations expected 0", viol); else n_pass++;
    endtask

    task automatic test_stall;
        logic ok;
        int a0;
        engine_busy = 1'b0;
        frame_ready = 1'b1;
        do_reset(1);
        input_signal_valid = 1'b1;
        wait_beats(2, 100, ok);
        frame_ready = 1'b0;
        a0 = acc_cnt;
        repeat (10) @(posedge clk);
        #1;
        n_checks++; if (acc_cnt - a0 > 2) $display("FAIL stall_accepts: got %0d expected <=2", acc_cnt - a0); else n_pass++;
        n_checks++; if (bq.size() !== 2) $display("FAIL stall_beats: got %0d expected 2", bq.size()); else n_pass++;
        frame_ready = 1'b1;
        wait_beats(16, 200, ok);
        if (!ok) begin n_checks++; $display("FAIL stall_timeout: got %0d beats expected 16", bq.size()); end
        else for (int i = 0; i < 16; i++) begin
            n_checks++; if (bq[i] !== DW'((i / 8) * 4 + (i % 8) + 1)) $display("FAIL stall_data[%0d]: got %0d expected %0d", i, bq[i], (i / 8) * 4 + (i % 8) + 1); else n_pass++;
        end
        n_checks++; if (viol !== 0) $display("FAIL stall_stability: got %0d violations expected 0", viol); else n_pass++;
    endtask

    task automatic test_reset_mid;
        logic ok;
        engine_busy = 1'b0;
        frame_ready = 1'b1;
        do_reset(1);
        input_signal_valid = 1'b1;
        wait_beats(12, 200, ok);
        n_checks++; if (frame_count !== 16'd1) $display("FAIL mid_pre_count: got %0d expected 1", frame_count); else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (frame_valid !== 1'b0) $display("FAIL mid_valid_during: got %0b expected 0", frame_valid); else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        next_sample = 101;
        input_signal_data = DW'(101);
        @(negedge clk);
        n_checks++; if (state_dbg !== 2'd0) $display("FAIL mid_state: got %0d expected 0", state_dbg); else n_pass++;
        n_checks++; if (frame_count !== 16'd0) $display("FAIL mid_count: got %0d expected 0", frame_count); else n_pass++;
        n_checks++; if (bq.size() !== 12) $display("FAIL mid_no_more_beats: got %0d expected 12", bq.size()); else n_pass++;
        wait_beats(20, 200, ok);
        if (!ok) begin n_checks++; $display("FAIL mid_timeout: got %0d beats expected 20", bq.size()); end
        else for (int i = 0; i < 8; i++) begin
            n_checks++; if (bq[12 + i] !== DW'(101 + i)) $display("FAIL mid_data[%0d]: got %0d expected %0d", i, bq[12 + i], 101 + i); else n_pass++;
        end
    endtask

    task automatic test_wrap;
        logic ok;
        engine_busy = 1'b0;
        frame_ready = 1'b1;
        do_reset(1);
        input_signal_valid = 1'b1;
        wait_beats(8, 100, ok);
        n_checks++; if (frame_count !== 16'd1) $display("FAIL wrap_first: got %0h expected 1", frame_count); else n_pass++;
        force dut.r_frame_count = 16'hFFFE;
        @(posedge clk); #1;
        release dut.r_frame_count;
        wait_beats(16, 100, ok);
        n_checks++; if (frame_count !== 16'hFFFF) $display("FAIL wrap_ffff: got %0h expected ffff", frame_count); else n_pass++;
        wait_beats(24, 100, ok);
        n_checks++; if (frame_count !== 16'h0000) $display("FAIL wrap_zero: got %0h expected 0", frame_count); else n_pass++;
        if (!ok) begin n_checks++; $display("FAIL wrap_timeout: got %0d beats expected 24", bq.size()); end
        else for (int i = 8; i < 24; i++) begin
            n_checks++; if (bq[i] !== DW'((i / 8) * 4 + (i % 8) + 1)) $display("FAIL wrap_data[%0d]: got %0d expected %0d", i, bq[i], (i / 8) * 4 + (i % 8) + 1); else n_pass++;
        end
    endtask

    initial begin
        test_reset;
        test_stream;
        test_engine_busy;
        test_ready_toggle;
        test_stall;
        test_reset_mid;
        test_wrap;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
